// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-ported fixed-latency memory between fetch (IF) and data (DM).
// Data wins by default; a saturating starvation counter forces a fetch grant after STARVE_MAX losses.
module unified_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_func3,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic              grant, grant_dm;
  logic              owner_dm_q;
  logic              we_q;
  logic [2:0]        wait_cnt_q;
  logic [3:0]        starve_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;
  logic              if_ack_q, dm_ack_q;

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    grant_dm = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dm_req || if_req) begin
          grant    = 1'b1;
          // Fetch wins only when it is also requesting and has lost STARVE_MAX times in a row.
          grant_dm = dm_req && !(if_req && (starve_q == 4'(STARVE_MAX)));
          state_d  = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait:  if (wait_cnt_q == 3'd1) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      owner_dm_q <= 1'b0;
      we_q       <= 1'b0;
      wait_cnt_q <= '0;
      starve_q   <= '0;
      func3_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        owner_dm_q <= grant_dm;
        we_q       <= grant_dm & dm_we;
        addr_q     <= grant_dm ? dm_addr : if_addr;
        func3_q    <= grant_dm ? dm_func3 : 3'b010;
        wdata_q    <= grant_dm ? dm_wdata : '0;
        if (!grant_dm) begin
          starve_q <= '0;
        end else if (if_req && (starve_q < 4'(STARVE_MAX))) begin
          starve_q <= starve_q + 4'd1;
        end
      end
      if (state_q == StIssue) wait_cnt_q <= 3'(MEM_LAT);
      if (state_q == StWait)  wait_cnt_q <= wait_cnt_q - 3'd1;
    end
  end

  // Read data and acks are registered; they update on the last WAIT cycle so they are seen in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
    end else begin
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      if ((state_q == StWait) && (wait_cnt_q == 3'd1)) begin
        if (owner_dm_q) begin
          dm_ack_q <= 1'b1;
          if (!we_q) dm_rdata_q <= mem_rdata;
        end else begin
          if_ack_q   <= 1'b1;
          if_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_en    = (state_q == StIssue);
  assign mem_we    = mem_en & we_q;
  assign mem_func3 = func3_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != StIdle);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign dm_stall  = dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus a randomized run scored against a
// transaction-level model (grant cycle -> issue/ack cycles, word-array memory).
module tb_unified_mem_arbiter;

  localparam int LAT  = 3;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        rst, mem_init;
  logic        if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [2:0]  dm_func3;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ack, if_stall, dm_ack, dm_stall, mem_en, mem_we, busy;
  logic [2:0]  mem_func3;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unified_mem_arbiter #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .MEM_LAT   (LAT),
    .STARVE_MAX(SMAX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .if_stall (if_stall),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_func3 (dm_func3),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ack   (dm_ack),
    .dm_stall (dm_stall),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_func3(mem_func3),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy)
  );

  function automatic logic [31:0] init_word(int i);
    logic [3:0] b;
    b = 4'(i);
    return {b ^ 4'd4, 28'h0A00093};
  endfunction

  // Memory environment: 16 words, read data valid only LAT cycles after the issue cycle.
  logic [31:0] env_mem [16];
  logic [31:0] noise = 32'h0;
  int          rd_due = -100;
  logic [3:0]  rd_idx = 4'd0;

  always @(posedge clk) begin
    noise <= $urandom();
    if (mem_init) begin
      for (int i = 0; i < 16; i++) env_mem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      env_mem[mem_addr[5:2]] <= mem_wdata;
    end
    if (mem_en && !mem_we) begin
      rd_due <= cyc + LAT;
      rd_idx <= mem_addr[5:2];
    end
  end
  assign mem_rdata = (cyc == rd_due) ? env_mem[rd_idx] : noise;

  // Reference model: one transaction at a time, timed by arithmetic from its grant cycle.
  logic [31:0] ref_mem [16];
  int          m_issue = -1, m_ack = -1, m_starve = 0;
  logic        m_owner_dm = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;
  logic [2:0]  m_func3 = '0;
  logic        m_dm_win;
  assign m_dm_win = dm_req && !(if_req && (m_starve == SMAX));

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) ref_mem[i] <= init_word(i);
    end
    if (rst) begin
      m_issue <= -1;  m_ack <= -1;  m_starve <= 0;
      m_owner_dm <= 1'b0;  m_we <= 1'b0;  m_addr <= '0;  m_wdata <= '0;  m_func3 <= '0;
      m_if_rdata <= '0;  m_dm_rdata <= '0;
    end else begin
      if ((cyc + 1 == m_ack) && !m_we) begin
        if (m_owner_dm) m_dm_rdata <= ref_mem[m_addr[5:2]];
        else            m_if_rdata <= ref_mem[m_addr[5:2]];
      end
      if ((cyc > m_ack) && (if_req || dm_req)) begin
        m_owner_dm <= m_dm_win;
        m_we       <= m_dm_win && dm_we;
        m_addr     <= m_dm_win ? dm_addr : if_addr;
        m_func3    <= m_dm_win ? dm_func3 : 3'b010;
        m_wdata    <= m_dm_win ? dm_wdata : 32'h0;
        m_issue    <= cyc + 1;
        m_ack      <= cyc + 2 + LAT;
        if (m_dm_win && dm_we) ref_mem[dm_addr[5:2]] <= dm_wdata;
        if (!m_dm_win)   m_starve <= 0;
        else if (if_req) m_starve <= (m_starve < SMAX) ? m_starve + 1 : SMAX;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;  mem_init = 1'b1;
    if_req = 1'b0;  if_addr = '0;
    dm_req = 1'b0;  dm_we = 1'b0;  dm_func3 = '0;  dm_addr = '0;  dm_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({if_ack, dm_ack, mem_en, mem_we, busy, mem_func3} !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0", {if_ack, dm_ack, mem_en, mem_we, busy, mem_func3});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h %h %h %h expected 0", mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    @(posedge clk); #1;
    rst = 1'b0;  mem_init = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_single_fetch();
    for (int k = 0; k <= LAT + 3; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin if_req = 1'b1; if_addr = 32'h0000_0010; end
      if (k == LAT + 3) if_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mem_en, busy, if_ack} !== {k == 1, (k >= 1) && (k <= LAT + 2), k == LAT + 2}) begin
        n_fail++;
        $display("FAIL fetch_timing k=%0d: got en/busy/ack=%b expected %b", k,
                 {mem_en, busy, if_ack}, {k == 1, (k >= 1) && (k <= LAT + 2), k == LAT + 2});
      end
      if (k == 1) begin
        n_checks++;
        if ({mem_addr, mem_we, mem_func3, mem_wdata} !== {32'h10, 1'b0, 3'b010, 32'h0}) begin
          n_fail++;
          $display("FAIL fetch_issue: got addr=%h we=%b f3=%b wd=%h expected 10/0/010/0",
                   mem_addr, mem_we, mem_func3, mem_wdata);
        end
      end
      if (k == LAT + 2) begin
        n_checks++;
        if ({if_rdata, if_stall, dm_ack} !== {32'h00A00093, 1'b0, 1'b0}) begin
          n_fail++;
          $display("FAIL fetch_resp: got rdata=%h stall=%b dm_ack=%b expected 00a00093/0/0",
                   if_rdata, if_stall, dm_ack);
        end
      end
    end
  endtask

  task automatic test_store_load();
    for (int j = 0; j < 2; j++) begin
      for (int k = 0; k <= LAT + 3; k++) begin
        @(posedge clk); #1;
        if (k == 0) begin
          dm_req = 1'b1;  dm_we = (j == 0);  dm_addr = 32'h100;  dm_func3 = 3'b010;
          dm_wdata = (j == 0) ? 32'hDEADBEEF : 32'h0;
        end
        if (k == LAT + 3) dm_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, dm_ack, if_ack} !== {k == 1, (k == 1) && (j == 0), k == LAT + 2, 1'b0}) begin
          n_fail++;
          $display("FAIL storeload_timing j=%0d k=%0d: got en/we/ack/if_ack=%b", j, k,
                   {mem_en, mem_we, dm_ack, if_ack});
        end
        if (k == 1) begin
          n_checks++;
          if ({mem_addr, mem_wdata} !== {32'h100, (j == 0) ? 32'hDEADBEEF : 32'h0}) begin
            n_fail++;
            $display("FAIL storeload_issue j=%0d: got addr=%h wdata=%h", j, mem_addr, mem_wdata);
          end
        end
        if (k == LAT + 2) begin
          n_checks++;
          if (dm_rdata !== ((j == 0) ? 32'h0 : 32'hDEADBEEF)) begin
            n_fail++;
            $display("FAIL storeload_rdata j=%0d: got %h expected %h", j, dm_rdata,
                     (j == 0) ? 32'h0 : 32'hDEADBEEF);
          end
        end
      end
    end
  endtask

  task automatic test_stall();
    for (int k = 0; k <= 2 * LAT + 6; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin if_req = 1'b1; if_addr = 32'h20; end
      if (k == 2) begin
        dm_req = 1'b1;  dm_we = 1'b0;  dm_addr = 32'h100;  dm_wdata = '0;  dm_func3 = 3'b000;
      end
      if (k == LAT + 3)     if_req = 1'b0;
      if (k == 2 * LAT + 6) dm_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({if_stall, dm_stall, if_ack, dm_ack} !==
          {k <= LAT + 1, (k >= 2) && (k < 2 * LAT + 5), k == LAT + 2, k == 2 * LAT + 5}) begin
        n_fail++;
        $display("FAIL stall k=%0d: got if_stall/dm_stall/if_ack/dm_ack=%b", k,
                 {if_stall, dm_stall, if_ack, dm_ack});
      end
      if (k == 2 * LAT + 5) begin
        n_checks++;
        if (dm_rdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL stall_rdata: got %h expected deadbeef", dm_rdata);
        end
      end
    end
  endtask

  task automatic test_contention();
    int acks = 0, last = 0, waited = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;  if_req = 1'b1;  if_addr = 32'h40;
    dm_req = 1'b1;  dm_we = 1'b0;  dm_addr = 32'h100;  dm_func3 = 3'b100;
    while ((acks < 10) && (waited < 10 * (LAT + 3) + 10)) begin
      @(negedge clk);
      waited++;
      n_checks++;
      if (if_ack && dm_ack) begin
        n_fail++;
        $display("FAIL contention_dual_ack: got both acks expected at most one");
      end else if (if_ack || dm_ack) begin
        n_checks++;
        if (dm_ack !== ((acks % 5) != 4)) begin
          n_fail++;
          $display("FAIL contention_order ack#%0d: got dm_ack=%b expected %b", acks, dm_ack,
                   (acks % 5) != 4);
        end
        if (acks > 0) begin
          n_checks++;
          if (cyc - last != LAT + 3) begin
            n_fail++;
            $display("FAIL contention_spacing: got %0d cycles expected %0d", cyc - last, LAT + 3);
          end
        end
        last = cyc;
        acks++;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (acks != 10) begin
      n_fail++;
      $display("FAIL contention_timeout: got %0d acks expected 10", acks);
    end
    if_req = 1'b0;  dm_req = 1'b0;
    repeat (LAT + 3) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k <= LAT + 6; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        dm_req = 1'b1;  dm_we = 1'b0;  dm_addr = 32'h100;  dm_wdata = '0;  dm_func3 = 3'b010;
      end
      if (k == 2) rst = 1'b1;
      if (k == 3) rst = 1'b0;
      if (k == LAT + 6) dm_req = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({dm_ack, mem_en} !== {k == LAT + 5, (k == 1) || (k == 4)}) begin
        n_fail++;
        $display("FAIL reset_mid_timing k=%0d: got ack/en=%b expected %b", k, {dm_ack, mem_en},
                 {k == LAT + 5, (k == 1) || (k == 4)});
      end
      if (k == 3) begin
        n_checks++;
        if ({busy, mem_we, if_ack, mem_func3, mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
          n_fail++;
          $display("FAIL reset_mid_clear: got busy=%b addr=%h wdata=%h dm_rdata=%h expected 0",
                   busy, mem_addr, mem_wdata, dm_rdata);
        end
      end
      if (k == LAT + 5) begin
        n_checks++;
        if (dm_rdata !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL reset_mid_rdata: got %h expected deadbeef", dm_rdata);
        end
      end
    end
  endtask

  task automatic test_random();
    logic if_seen = 1'b0, dm_seen = 1'b0;
    logic [6:0] exp_ctl;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 99) == 0);
      if (!if_req || if_seen) begin
        if_req  = ($urandom_range(0, 2) != 0);
        if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!dm_req || dm_seen) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = 1'($urandom_range(0, 1));
        dm_func3 = 3'($urandom_range(0, 7));
        dm_addr  = $urandom() & 32'hFFFF_FFFC;
        dm_wdata = $urandom();
      end
      @(negedge clk);
      exp_ctl[6] = (cyc == m_ack) && !m_owner_dm;
      exp_ctl[5] = (cyc == m_ack) && m_owner_dm;
      exp_ctl[4] = (cyc == m_issue);
      exp_ctl[3] = (cyc == m_issue) && m_we;
      exp_ctl[2] = (cyc >= m_issue) && (cyc <= m_ack);
      exp_ctl[1] = if_req && !exp_ctl[6];
      exp_ctl[0] = dm_req && !exp_ctl[5];
      n_checks++;
      if ({if_ack, dm_ack, mem_en, mem_we, busy, if_stall, dm_stall} !== exp_ctl) begin
        n_fail++;
        $display("FAIL rand_ctl cyc=%0d: got %b expected %b", cyc,
                 {if_ack, dm_ack, mem_en, mem_we, busy, if_stall, dm_stall}, exp_ctl);
      end
      n_checks++;
      if ({mem_addr, mem_func3, mem_wdata} !== {m_addr, m_func3, m_wdata}) begin
        n_fail++;
        $display("FAIL rand_mem cyc=%0d: got %h/%b/%h expected %h/%b/%h", cyc, mem_addr,
                 mem_func3, mem_wdata, m_addr, m_func3, m_wdata);
      end
      n_checks++;
      if ({if_rdata, dm_rdata} !== {m_if_rdata, m_dm_rdata}) begin
        n_fail++;
        $display("FAIL rand_rdata cyc=%0d: got %h/%h expected %h/%h", cyc, if_rdata, dm_rdata,
                 m_if_rdata, m_dm_rdata);
      end
      if_seen = if_ack;
      dm_seen = dm_ack;
    end
    @(posedge clk); #1;
    rst = 1'b0;  if_req = 1'b0;  dm_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store_load();
    test_stall();
    test_contention();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
